// File: rtl/mips_bus_arbiter.sv
// Two-port (fetch/data) arbiter onto a single Avalon-style memory bus with a timeout watchdog.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants under contention instead of fixed data-port priority.
module mips_bus_arbiter #(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_READDATA   = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [31:0] m_writedata,
   output logic [3:0]  m_byteenable,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic        bus_error
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t        state_r, state_n_s;
   logic          grant_d_r, grant_d_n_s;     // 1: data port owns the bus, 0: fetch port
   logic [CW-1:0] cnt_r, cnt_n_s;
   logic          bus_error_r, bus_error_n_s;
`ifdef ARB_ROUND_ROBIN_EN
   logic          last_grant_d_r, last_grant_d_n_s;
`endif

   logic i_req_s, d_req_s, busy_s, gnt_req_s;
   logic done_s, timeout_s, complete_s, i_done_s, d_done_s, arb_d_s;

   // Request decode and completion qualification
   always_comb begin
      i_req_s    = i_read;
      d_req_s    = d_read | d_write;
      busy_s     = (state_r == ST_BUSY);
      gnt_req_s  = grant_d_r ? d_req_s : i_req_s;
      done_s     = busy_s & gnt_req_s & ~m_waitrequest;
      timeout_s  = busy_s & gnt_req_s & m_waitrequest & (cnt_r == CW'(TIMEOUT_CYCLES - 1));
      complete_s = done_s | timeout_s;
      i_done_s   = complete_s & ~grant_d_r;
      d_done_s   = complete_s & grant_d_r;
   end

   // Arbitration choice used when leaving IDLE
   always_comb begin
      arb_d_s = 1'b0;
      if (i_req_s && d_req_s) begin
`ifdef ARB_ROUND_ROBIN_EN
         arb_d_s = ~last_grant_d_r;
`else
         arb_d_s = 1'b1;
`endif
      end else begin
         arb_d_s = d_req_s;
      end
   end

   // Next-state, watchdog counter and sticky error
   always_comb begin
      state_n_s     = state_r;
      grant_d_n_s   = grant_d_r;
      cnt_n_s       = cnt_r;
      bus_error_n_s = bus_error_r;
      case (state_r)
         ST_IDLE: begin
            if (i_req_s || d_req_s) begin
               state_n_s   = ST_BUSY;
               grant_d_n_s = arb_d_s;
               cnt_n_s     = {CW{1'b0}};
            end else begin
               state_n_s   = ST_IDLE;
            end
         end
         ST_BUSY: begin
            // an abandoned request (granted port dropped it) returns to IDLE silently
            if (complete_s || !gnt_req_s) begin
               state_n_s = ST_IDLE;
               cnt_n_s   = {CW{1'b0}};
            end else begin
               cnt_n_s   = cnt_r + CW'(1);
            end
         end
         default: begin
            state_n_s = ST_IDLE;
            cnt_n_s   = {CW{1'b0}};
         end
      endcase
      if (timeout_s) begin
         bus_error_n_s = 1'b1;
      end else begin
         bus_error_n_s = bus_error_r;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   // Remember the owner of the last completed transaction
   always_comb begin
      if (complete_s) begin
         last_grant_d_n_s = grant_d_r;
      end else begin
         last_grant_d_n_s = last_grant_d_r;
      end
   end

   // Round-robin history register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_d_r <= 1'b0;
      end else begin
         last_grant_d_r <= last_grant_d_n_s;
      end
   end
`endif

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         grant_d_r   <= 1'b0;
         cnt_r       <= {CW{1'b0}};
         bus_error_r <= 1'b0;
      end else begin
         state_r     <= state_n_s;
         grant_d_r   <= grant_d_n_s;
         cnt_r       <= cnt_n_s;
         bus_error_r <= bus_error_n_s;
      end
   end

   // Memory-side mux and per-port handshake
   always_comb begin
      m_address     = 32'h0000_0000;
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_writedata   = 32'h0000_0000;
      m_byteenable  = 4'h0;
      if (busy_s) begin
         if (grant_d_r) begin
            m_address    = d_address;
            m_write      = d_write & ~timeout_s;
            m_read       = d_read & ~d_write & ~timeout_s;
            m_writedata  = d_writedata;
            m_byteenable = d_byteenable;
         end else begin
            m_address    = i_address;
            m_read       = i_read & ~timeout_s;
            m_byteenable = 4'hF;
         end
      end else begin
         m_address = 32'h0000_0000;
      end
      i_waitrequest = i_req_s & ~i_done_s;
      d_waitrequest = d_req_s & ~d_done_s;
      if (i_done_s) begin
         i_readdata = timeout_s ? ERR_READDATA : m_readdata;
      end else begin
         i_readdata = 32'h0000_0000;
      end
      if (d_done_s) begin
         d_readdata = timeout_s ? ERR_READDATA : m_readdata;
      end else begin
         d_readdata = 32'h0000_0000;
      end
      bus_error = bus_error_r;
   end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: per-cycle vector table plus timeout, reset and contention sequences.
module tb_mips_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_address, d_address, d_writedata, m_readdata;
   logic        i_read, d_read, d_write, m_waitrequest;
   logic [3:0]  d_byteenable;
   logic        i_waitrequest, d_waitrequest, m_read, m_write, bus_error;
   logic [31:0] i_readdata, d_readdata, m_address, m_writedata;
   logic [3:0]  m_byteenable;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] Z = 32'h0;

   typedef struct {
      logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [31:0] dwd;
      logic [3:0] dbe; logic mw; logic [31:0] mrd;
      logic e_iw; logic [31:0] e_ird; logic e_dw; logic [31:0] e_drd; logic [31:0] e_ma;
      logic e_mr; logic e_mwr; logic [3:0] e_mbe; logic [31:0] e_mwd;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   mips_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_READDATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst(rst),
      .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
      .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
      .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
      .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
      .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
      .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                        input logic mw, input logic [31:0] mrd);
      i_read = ir; i_address = ia; d_read = dr; d_write = dw; d_address = da;
      d_writedata = dwd; d_byteenable = dbe; m_waitrequest = mw; m_readdata = mrd;
   endtask

   initial begin
      bit exp_d;
      vecs[0]  = '{1'b1,32'h100,1'b0,1'b0,Z,Z,4'h0,1'b0,32'h2402000A, 1'b1,Z,1'b0,Z,Z,1'b0,1'b0,4'h0,Z};
      vecs[1]  = '{1'b1,32'h100,1'b0,1'b0,Z,Z,4'h0,1'b0,32'h2402000A, 1'b0,32'h2402000A,1'b0,Z,32'h100,1'b1,1'b0,4'hF,Z};
      vecs[2]  = '{1'b0,Z,1'b0,1'b0,Z,Z,4'h0,1'b0,32'h2402000A, 1'b0,Z,1'b0,Z,Z,1'b0,1'b0,4'h0,Z};
      vecs[3]  = '{1'b0,Z,1'b0,1'b1,32'h200,32'h12345678,4'h3,1'b1,32'h55AA55AA, 1'b0,Z,1'b1,Z,Z,1'b0,1'b0,4'h0,Z};
      for (int k = 4; k <= 6; k++)
         vecs[k] = '{1'b0,Z,1'b0,1'b1,32'h200,32'h12345678,4'h3,1'b1,32'h55AA55AA, 1'b0,Z,1'b1,Z,32'h200,1'b0,1'b1,4'h3,32'h12345678};
      vecs[7]  = '{1'b0,Z,1'b0,1'b1,32'h200,32'h12345678,4'h3,1'b0,32'h55AA55AA, 1'b0,Z,1'b0,32'h55AA55AA,32'h200,1'b0,1'b1,4'h3,32'h12345678};
      vecs[8]  = '{1'b0,Z,1'b0,1'b0,Z,Z,4'h0,1'b0,Z, 1'b0,Z,1'b0,Z,Z,1'b0,1'b0,4'h0,Z};
      vecs[9]  = '{1'b0,Z,1'b1,1'b1,32'h300,32'hA5A5A5A5,4'hF,1'b0,32'h11112222, 1'b0,Z,1'b1,Z,Z,1'b0,1'b0,4'h0,Z};
      vecs[10] = '{1'b0,Z,1'b1,1'b1,32'h300,32'hA5A5A5A5,4'hF,1'b0,32'h11112222, 1'b0,Z,1'b0,32'h11112222,32'h300,1'b0,1'b1,4'hF,32'hA5A5A5A5};
      vecs[11] = vecs[8];
      vecs[12] = '{1'b0,Z,1'b1,1'b0,32'h600,Z,4'hF,1'b1,Z, 1'b0,Z,1'b1,Z,Z,1'b0,1'b0,4'h0,Z};
      vecs[13] = '{1'b1,32'h104,1'b1,1'b0,32'h600,Z,4'hF,1'b0,32'hBBBB0000, 1'b1,Z,1'b0,32'hBBBB0000,32'h600,1'b1,1'b0,4'hF,Z};
      vecs[14] = '{1'b1,32'h104,1'b0,1'b0,Z,Z,4'h0,1'b0,32'hBBBB0000, 1'b1,Z,1'b0,Z,Z,1'b0,1'b0,4'h0,Z};
      vecs[15] = '{1'b1,32'h104,1'b0,1'b0,Z,Z,4'h0,1'b0,32'hBBBB0000, 1'b0,32'hBBBB0000,1'b0,Z,32'h104,1'b1,1'b0,4'hF,Z};
      vecs[16] = vecs[8];
      vecs[17] = '{1'b0,Z,1'b1,1'b0,32'h700,Z,4'h0,1'b1,Z, 1'b0,Z,1'b1,Z,Z,1'b0,1'b0,4'h0,Z};
      vecs[18] = '{1'b0,Z,1'b1,1'b0,32'h700,Z,4'h0,1'b1,Z, 1'b0,Z,1'b1,Z,32'h700,1'b1,1'b0,4'h0,Z};
      vecs[19] = '{1'b0,Z,1'b0,1'b0,32'h700,Z,4'h0,1'b1,Z, 1'b0,Z,1'b0,Z,32'h700,1'b0,1'b0,4'h0,Z};
      vecs[20] = '{1'b0,Z,1'b1,1'b0,32'h700,Z,4'h0,1'b0,32'h0000C0DE, 1'b0,Z,1'b1,Z,Z,1'b0,1'b0,4'h0,Z};
      vecs[21] = '{1'b0,Z,1'b1,1'b0,32'h700,Z,4'h0,1'b0,32'h0000C0DE, 1'b0,Z,1'b0,32'h0000C0DE,32'h700,1'b1,1'b0,4'h0,Z};
      vecs[22] = vecs[8];

      // reset state
      rst = 1'b1;
      drive(1'b0, Z, 1'b0, 1'b0, Z, Z, 4'h0, 1'b0, Z);
      @(negedge clk); #1;
      chk("rst_m_read", {31'b0, m_read}, 32'h0);
      chk("rst_m_write", {31'b0, m_write}, 32'h0);
      chk("rst_bus_error", {31'b0, bus_error}, 32'h0);
      chk("rst_m_address", m_address, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // per-cycle vector table
      for (int v = 0; v < NV; v++) begin
         @(negedge clk);
         drive(vecs[v].ir, vecs[v].ia, vecs[v].dr, vecs[v].dw, vecs[v].da, vecs[v].dwd,
               vecs[v].dbe, vecs[v].mw, vecs[v].mrd);
         #1;
         chk($sformatf("v%0d_i_wait", v), {31'b0, i_waitrequest}, {31'b0, vecs[v].e_iw});
         chk($sformatf("v%0d_i_rdata", v), i_readdata, vecs[v].e_ird);
         chk($sformatf("v%0d_d_wait", v), {31'b0, d_waitrequest}, {31'b0, vecs[v].e_dw});
         chk($sformatf("v%0d_d_rdata", v), d_readdata, vecs[v].e_drd);
         chk($sformatf("v%0d_m_addr", v), m_address, vecs[v].e_ma);
         chk($sformatf("v%0d_m_read", v), {31'b0, m_read}, {31'b0, vecs[v].e_mr});
         chk($sformatf("v%0d_m_write", v), {31'b0, m_write}, {31'b0, vecs[v].e_mwr});
         chk($sformatf("v%0d_m_be", v), {28'b0, m_byteenable}, {28'b0, vecs[v].e_mbe});
         chk($sformatf("v%0d_m_wdata", v), m_writedata, vecs[v].e_mwd);
         chk($sformatf("v%0d_bus_error", v), {31'b0, bus_error}, 32'h0);
      end

      // watchdog: memory never completes a data read
      @(negedge clk);
      drive(1'b0, Z, 1'b1, 1'b0, 32'h500, Z, 4'hF, 1'b1, 32'h12);
      #1 chk("to_idle_d_wait", {31'b0, d_waitrequest}, 32'h1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk); #1;
         if (k < 8) begin
            chk($sformatf("to_busy%0d_d_wait", k), {31'b0, d_waitrequest}, 32'h1);
            chk($sformatf("to_busy%0d_m_read", k), {31'b0, m_read}, 32'h1);
            chk($sformatf("to_busy%0d_bus_error", k), {31'b0, bus_error}, 32'h0);
         end else begin
            chk("to_abort_d_wait", {31'b0, d_waitrequest}, 32'h0);
            chk("to_abort_d_rdata", d_readdata, 32'hDEADBEEF);
            chk("to_abort_m_read", {31'b0, m_read}, 32'h0);
         end
      end
      @(negedge clk);
      drive(1'b0, Z, 1'b0, 1'b0, Z, Z, 4'h0, 1'b0, Z);
      #1 chk("to_sticky_bus_error", {31'b0, bus_error}, 32'h1);
      @(negedge clk);
      drive(1'b1, 32'h108, 1'b0, 1'b0, Z, Z, 4'h0, 1'b0, 32'h2402000B);
      #1 chk("to_next_idle_i_wait", {31'b0, i_waitrequest}, 32'h1);
      @(negedge clk); #1;
      chk("to_next_i_wait", {31'b0, i_waitrequest}, 32'h0);
      chk("to_next_i_rdata", i_readdata, 32'h2402000B);
      chk("to_next_bus_error", {31'b0, bus_error}, 32'h1);
      @(negedge clk);
      drive(1'b0, Z, 1'b0, 1'b0, Z, Z, 4'h0, 1'b0, Z);

      // asynchronous reset in the middle of a stalled fetch
      @(negedge clk);
      drive(1'b1, 32'h10C, 1'b0, 1'b0, Z, Z, 4'h0, 1'b1, 32'h3C01ABCD);
      @(negedge clk); #1;
      chk("mr_busy_m_read", {31'b0, m_read}, 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("mr_m_read", {31'b0, m_read}, 32'h0);
      chk("mr_m_write", {31'b0, m_write}, 32'h0);
      chk("mr_bus_error", {31'b0, bus_error}, 32'h0);
      chk("mr_i_wait", {31'b0, i_waitrequest}, 32'h1);
      chk("mr_i_rdata", i_readdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      m_waitrequest = 1'b0;
      #1;
      chk("mr_after_idle_m_read", {31'b0, m_read}, 32'h0);
      chk("mr_after_idle_i_wait", {31'b0, i_waitrequest}, 32'h1);
      @(negedge clk); #1;
      chk("mr_after_i_wait", {31'b0, i_waitrequest}, 32'h0);
      chk("mr_after_i_rdata", i_readdata, 32'h3C01ABCD);
      chk("mr_after_m_addr", m_address, 32'h10C);

      // continuous contention right after reset (history starts at fetch)
      @(negedge clk);
      drive(1'b0, Z, 1'b0, 1'b0, Z, Z, 4'h0, 1'b0, Z);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         drive(1'b1, 32'h104, 1'b1, 1'b0, 32'h400, Z, 4'hF, 1'b0, 32'h77);
         #1;
         chk($sformatf("arb%0d_idle_m_read", t), {31'b0, m_read}, 32'h0);
         chk($sformatf("arb%0d_idle_d_wait", t), {31'b0, d_waitrequest}, 32'h1);
         chk($sformatf("arb%0d_idle_i_wait", t), {31'b0, i_waitrequest}, 32'h1);
`ifdef ARB_ROUND_ROBIN_EN
         exp_d = (t % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         @(negedge clk); #1;
         chk($sformatf("arb%0d_d_wait", t), {31'b0, d_waitrequest}, {31'b0, ~exp_d});
         chk($sformatf("arb%0d_i_wait", t), {31'b0, i_waitrequest}, {31'b0, exp_d});
         chk($sformatf("arb%0d_m_addr", t), m_address, exp_d ? 32'h400 : 32'h104);
      end
      @(negedge clk);
      drive(1'b0, Z, 1'b0, 1'b0, Z, Z, 4'h0, 1'b0, Z);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
